// File: rtl/id_alu_issue_pkg.sv
// Shared definitions for the RV32I ALU issue stage: opcodes, funct7 values,
// ALU op encodings (shared with the ALU), skid-buffer states and entry layout.
package id_alu_issue_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_SLL  = 4'b0010;
  localparam logic [3:0] ALU_SLT  = 4'b0011;
  localparam logic [3:0] ALU_SLTU = 4'b0100;
  localparam logic [3:0] ALU_XOR  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_OR   = 4'b1000;
  localparam logic [3:0] ALU_AND  = 4'b1001;
  localparam logic [3:0] ALU_LUI  = 4'b1010;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } issue_state_e;

  typedef struct packed {
    logic [3:0]  alu_op;
    logic [31:0] alu1;
    logic [31:0] alu2;
    logic [4:0]  rd;
    logic        rd_we;
    logic        illegal;
  } issue_entry_t;

  // ALU op selected by funct3 when funct7 is the base (all-zero) encoding.
  function automatic logic [3:0] f3_base_op(input logic [2:0] f3);
    case (f3)
      3'b000:  f3_base_op = ALU_ADD;
      3'b001:  f3_base_op = ALU_SLL;
      3'b010:  f3_base_op = ALU_SLT;
      3'b011:  f3_base_op = ALU_SLTU;
      3'b100:  f3_base_op = ALU_XOR;
      3'b101:  f3_base_op = ALU_SRL;
      3'b110:  f3_base_op = ALU_OR;
      default: f3_base_op = ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/id_alu_issue_alu_decode.sv
// Combinational RV32I ALU-class decoder: instruction, pc and register data in,
// ALU op, operands, destination and legality out.
module alu_decode
  import id_alu_issue_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  output logic [3:0]      alu_op_o,
  output logic [XLEN-1:0] alu1_o,
  output logic [XLEN-1:0] alu2_o,
  output logic [4:0]      rd_o,
  output logic            rd_we_o,
  output logic            illegal_o
);

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [3:0] op;
  logic [XLEN-1:0] a1;
  logic [XLEN-1:0] a2;
  logic ill;

  assign opc = instr_i[6:0];
  assign f3  = instr_i[14:12];
  assign f7  = instr_i[31:25];

  always_comb begin
    op  = ALU_ADD;
    a1  = '0;
    a2  = '0;
    ill = 1'b0;
    case (opc)
      OPC_OP: begin
        a1 = rs1_data_i;
        a2 = rs2_data_i;
        if (f7 == F7_BASE) op = f3_base_op(f3);
        else if (f7 == F7_ALT && f3 == 3'b000) op = ALU_SUB;
        else if (f7 == F7_ALT && f3 == 3'b101) op = ALU_SRA;
        else ill = 1'b1;
      end
      OPC_OP_IMM: begin
        a1 = rs1_data_i;
        a2 = {{20{instr_i[31]}}, instr_i[31:20]};
        op = f3_base_op(f3);
        // Shift-immediates carry shamt in [24:20] and a funct7 in [31:25].
        if (f3 == 3'b001 || f3 == 3'b101) begin
          a2 = {27'b0, instr_i[24:20]};
          if (f3 == 3'b101 && f7 == F7_ALT) op = ALU_SRA;
          else if (f7 != F7_BASE) ill = 1'b1;
        end
      end
      OPC_LUI: begin
        op = ALU_LUI;
        a2 = {instr_i[31:12], 12'b0};
      end
      OPC_AUIPC: begin
        a1 = pc_i;
        a2 = {instr_i[31:12], 12'b0};
      end
      default: ill = 1'b1;
    endcase
    if (ill) begin
      op = ALU_ADD;
      a1 = '0;
      a2 = '0;
    end
  end

  assign alu_op_o  = op;
  assign alu1_o    = a1;
  assign alu2_o    = a2;
  assign rd_o      = instr_i[11:7];
  assign rd_we_o   = !ill && (instr_i[11:7] != 5'd0);
  assign illegal_o = ill;

endmodule

// File: rtl/id_alu_issue.sv
// Decode-to-execute issue stage: decodes into a 2-entry skid buffer so the
// upstream ready is registered while sustaining one instruction per clock.
module id_alu_issue
  import id_alu_issue_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic            flush_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [3:0]      alu_op_o,
  output logic [XLEN-1:0] alu1_o,
  output logic [XLEN-1:0] alu2_o,
  output logic [4:0]      rd_o,
  output logic            rd_we_o,
  output logic            illegal_o
);

  issue_entry_t dec_p0;
  issue_entry_t main_p1;
  issue_entry_t skid_p1;
  issue_state_e state, state_nx;
  logic accept, drain;

  alu_decode #(.XLEN(XLEN)) u_decode (
    .instr_i    (instr_i),
    .pc_i       (pc_i),
    .rs1_data_i (rs1_data_i),
    .rs2_data_i (rs2_data_i),
    .alu_op_o   (dec_p0.alu_op),
    .alu1_o     (dec_p0.alu1),
    .alu2_o     (dec_p0.alu2),
    .rd_o       (dec_p0.rd),
    .rd_we_o    (dec_p0.rd_we),
    .illegal_o  (dec_p0.illegal)
  );

  assign valid_o = (state != ST_EMPTY);
  assign accept  = valid_i && ready_o;
  assign drain   = valid_o && ready_i;

  always_comb begin
    state_nx = state;
    if (flush_i) begin
      state_nx = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: if (accept) state_nx = ST_ONE;
        ST_ONE:   if (accept && !drain) state_nx = ST_TWO;
                  else if (!accept && drain) state_nx = ST_EMPTY;
        ST_TWO:   if (drain) state_nx = ST_ONE;
        default:  state_nx = ST_EMPTY;
      endcase
    end
  end

  // Stage boundary: decoded entry registered into main / skid.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= ST_EMPTY;
      ready_o <= 1'b1;
      main_p1 <= '0;
      skid_p1 <= '0;
    end else begin
      state   <= state_nx;
      ready_o <= (state_nx != ST_TWO);
      if (!flush_i) begin
        case (state)
          ST_EMPTY: if (accept) main_p1 <= dec_p0;
          ST_ONE: begin
            if (accept && drain) main_p1 <= dec_p0;
            else if (accept) skid_p1 <= dec_p0;
          end
          ST_TWO: if (drain) main_p1 <= skid_p1;
          default: ;
        endcase
      end
    end
  end

  assign alu_op_o  = main_p1.alu_op;
  assign alu1_o    = main_p1.alu1;
  assign alu2_o    = main_p1.alu2;
  assign rd_o      = main_p1.rd;
  assign rd_we_o   = main_p1.rd_we;
  assign illegal_o = main_p1.illegal;

endmodule

// File: tb/tb_id_alu_issue.sv
// Bench for id_alu_issue: directed decode vectors plus randomized traffic
// scored against a queue-based FIFO model with a table-driven decoder.
module tb_id_alu_issue;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a1;
    logic [31:0] a2;
    logic [4:0]  rd;
    logic        we;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [31:0] instr = '0;
  logic [31:0] pc = '0;
  logic [31:0] rs1 = '0;
  logic [31:0] rs2 = '0;
  logic        flush = 1'b0;
  logic        valid_o;
  logic        ready_i = 1'b0;
  logic [3:0]  alu_op;
  logic [31:0] alu1;
  logic [31:0] alu2;
  logic [4:0]  rd;
  logic        rd_we;
  logic        illegal;
  logic [74:0] obs;

  int checks = 0;
  int errors = 0;
  exp_t mq[$];

  id_alu_issue #(.XLEN(32)) dut (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_i), .ready_o(ready_o),
    .instr_i(instr), .pc_i(pc), .rs1_data_i(rs1), .rs2_data_i(rs2),
    .flush_i(flush), .valid_o(valid_o), .ready_i(ready_i),
    .alu_op_o(alu_op), .alu1_o(alu1), .alu2_o(alu2), .rd_o(rd),
    .rd_we_o(rd_we), .illegal_o(illegal)
  );

  always #5 clk = ~clk;
  assign obs = {alu_op, alu1, alu2, rd, rd_we, illegal};

  function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] p,
                                      input logic [31:0] r1, input logic [31:0] r2);
    logic [3:0] tab [8];
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic legal;
    exp_t e;
    tab = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
    opc = ins[6:0];
    f3 = ins[14:12];
    f7 = ins[31:25];
    e = '0;
    e.rd = ins[11:7];
    legal = 1'b0;
    if (opc == 7'h33) begin
      legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
      e.op = (f7 == 7'h20) ? ((f3 == 3'd0) ? 4'd1 : 4'd7) : tab[f3];
      e.a1 = r1;
      e.a2 = r2;
    end else if (opc == 7'h13) begin
      if (f3 == 3'd1) legal = (f7 == 7'h00);
      else if (f3 == 3'd5) legal = (f7 == 7'h00 || f7 == 7'h20);
      else legal = 1'b1;
      e.op = (f3 == 3'd5 && f7 == 7'h20) ? 4'd7 : tab[f3];
      e.a1 = r1;
      e.a2 = (f3 == 3'd1 || f3 == 3'd5) ? 32'(ins[24:20]) : 32'(signed'(ins[31:20]));
    end else if (opc == 7'h37) begin
      legal = 1'b1;
      e.op = 4'd10;
      e.a2 = ins & 32'hFFFFF000;
    end else if (opc == 7'h17) begin
      legal = 1'b1;
      e.a1 = p;
      e.a2 = ins & 32'hFFFFF000;
    end
    if (!legal) begin
      e.op = 4'd0;
      e.a1 = '0;
      e.a2 = '0;
    end
    e.ill = !legal;
    e.we = legal && (e.rd != 5'd0);
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [6:0] opc;
    logic [6:0] f7;
    r = $urandom();
    case ($urandom_range(0, 5))
      0: opc = 7'h33;
      1: opc = 7'h13;
      2: opc = 7'h37;
      3: opc = 7'h17;
      4: opc = 7'h03;
      default: opc = r[6:0];
    endcase
    case ($urandom_range(0, 3))
      0, 1: f7 = 7'h00;
      2: f7 = 7'h20;
      default: f7 = r[31:25];
    endcase
    return {f7, r[24:7], opc};
  endfunction

  // FIFO model: entries present = queue depth; ready = depth below two.
  always @(posedge clk or negedge rst_n) begin
    int n;
    if (!rst_n) mq.delete();
    else if (flush) mq.delete();
    else begin
      n = mq.size();
      if (n > 0 && ready_i) void'(mq.pop_front());
      if (valid_i && n < 2) mq.push_back(ref_decode(instr, pc, rs1, rs2));
    end
  end

  task automatic set_in(input logic v, input logic [31:0] ins, input logic [31:0] p,
                        input logic [31:0] r1, input logic [31:0] r2,
                        input logic rdy, input logic fl);
    valid_i = v; instr = ins; pc = p; rs1 = r1; rs2 = r2; ready_i = rdy; flush = fl;
  endtask

  task automatic test_reset();
    set_in(1'b0, '0, '0, '0, '0, 1'b0, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", valid_o); end
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", ready_o); end
    checks++; if (obs !== 75'd0) begin errors++; $display("FAIL reset_payload got %h exp 0", obs); end
    rst_n = 1'b1;
    @(negedge clk); #1;
    checks++; if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
      errors++; $display("FAIL idle_after_reset got v=%b r=%b exp v=0 r=1", valid_o, ready_o);
    end
  endtask

  task automatic test_decode_directed();
    logic [31:0] vi [8];
    logic [31:0] vp [8];
    logic [31:0] v1 [8];
    logic [31:0] v2 [8];
    exp_t ve [8];
    vi[0] = 32'h002081B3; vp[0] = 0;         v1[0] = 5;            v2[0] = 7;
    ve[0] = {4'd0, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0};
    vi[1] = 32'h402081B3; vp[1] = 0;         v1[1] = 5;            v2[1] = 7;
    ve[1] = {4'd1, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0};
    vi[2] = 32'h40335293; vp[2] = 0;         v1[2] = 32'h80000000; v2[2] = 32'h55;
    ve[2] = {4'd7, 32'h80000000, 32'd3, 5'd5, 1'b1, 1'b0};
    vi[3] = 32'h123450B7; vp[3] = 32'h40;    v1[3] = 32'hDEAD;     v2[3] = 32'hBEEF;
    ve[3] = {4'd10, 32'd0, 32'h12345000, 5'd1, 1'b1, 1'b0};
    vi[4] = 32'h00001097; vp[4] = 32'h100;   v1[4] = 32'h1234;     v2[4] = 32'h9;
    ve[4] = {4'd0, 32'h100, 32'h1000, 5'd1, 1'b1, 1'b0};
    vi[5] = 32'hFFF00093; vp[5] = 0;         v1[5] = 32'h9;        v2[5] = 32'h3;
    ve[5] = {4'd0, 32'h9, 32'hFFFFFFFF, 5'd1, 1'b1, 1'b0};
    vi[6] = 32'h00012083; vp[6] = 32'h8;     v1[6] = 32'h77;       v2[6] = 32'h66;
    ve[6] = {4'd0, 32'd0, 32'd0, 5'd1, 1'b0, 1'b1};
    vi[7] = 32'h022081B3; vp[7] = 0;         v1[7] = 32'h11;       v2[7] = 32'h22;
    ve[7] = {4'd0, 32'd0, 32'd0, 5'd3, 1'b0, 1'b1};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      set_in(1'b1, vi[i], vp[i], v1[i], v2[i], 1'b1, 1'b0);
      @(negedge clk);
      valid_i = 1'b0;
      #1;
      checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL dir_valid[%0d] got %b exp 1", i, valid_o); end
      checks++; if (obs !== ve[i]) begin errors++; $display("FAIL dir_payload[%0d] got %h exp %h", i, obs, ve[i]); end
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [31:0] lst [4];
    exp_t ex [4];
    int k;
    int outn;
    int bound;
    for (int i = 0; i < 4; i++) begin
      lst[i] = rand_instr();
      ex[i] = ref_decode(lst[i], 32'h200 + 32'(i * 4), 32'(i + 10), 32'(i + 20));
    end
    k = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      set_in(1'b1, lst[k], 32'h200 + 32'(k * 4), 32'(k + 10), 32'(k + 20), 1'b0, 1'b0);
      #1;
      checks++;
      if (ready_o !== (c < 2)) begin errors++; $display("FAIL b2b_ready[%0d] got %b exp %b", c, ready_o, c < 2); end
      if (c < 2) k++;
    end
    outn = 0;
    bound = 0;
    while (outn < 4 && bound < 20) begin
      @(negedge clk);
      set_in(k < 4, lst[k % 4], 32'h200 + 32'((k % 4) * 4), 32'((k % 4) + 10), 32'((k % 4) + 20), 1'b1, 1'b0);
      #1;
      checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL b2b_gap[%0d] got %b exp 1", outn, valid_o); end
      checks++; if (obs !== ex[outn]) begin errors++; $display("FAIL b2b_order[%0d] got %h exp %h", outn, obs, ex[outn]); end
      if (valid_i && mq.size() < 2) k++;
      outn++;
      bound++;
    end
    checks++; if (outn != 4) begin errors++; $display("FAIL b2b_timeout got %0d exp 4", outn); end
    @(negedge clk);
    set_in(1'b0, '0, '0, '0, '0, 1'b1, 1'b0);
    #1;
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL b2b_dup got %b exp 0", valid_o); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      set_in(1'b1, 32'h002081B3, '0, 32'(i + 1), 32'(i + 2), 1'b0, 1'b0);
    end
    @(negedge clk);
    set_in(1'b1, 32'h123450B7, '0, '0, '0, 1'b0, 1'b0);
    #1;
    checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL flush_full_ready got %b exp 0", ready_o); end
    flush = 1'b1;
    @(negedge clk);
    set_in(1'b0, '0, '0, '0, '0, 1'b1, 1'b0);
    #1;
    checks++; if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
      errors++; $display("FAIL flush_state got v=%b r=%b exp v=0 r=1", valid_o, ready_o);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL flush_leak[%0d] got %b exp 0", i, valid_o); end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      set_in($urandom_range(0, 9) < 7, rand_instr(), $urandom(), $urandom(), $urandom(),
             $urandom_range(0, 9) < 6, $urandom_range(0, 31) == 0);
      #1;
      checks++;
      if (ready_o !== (mq.size() < 2)) begin errors++; $display("FAIL rnd_ready[%0d] got %b exp %b", c, ready_o, mq.size() < 2); end
      checks++;
      if (valid_o !== (mq.size() > 0)) begin errors++; $display("FAIL rnd_valid[%0d] got %b exp %b", c, valid_o, mq.size() > 0); end
      if (mq.size() > 0) begin
        checks++;
        if (obs !== mq[0]) begin errors++; $display("FAIL rnd_payload[%0d] got %h exp %h", c, obs, mq[0]); end
      end
    end
    @(negedge clk);
    set_in(1'b0, '0, '0, '0, '0, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      set_in(1'b1, 32'h00001097, 32'h300, '1, '1, 1'b0, 1'b0);
    end
    @(negedge clk);
    valid_i = 1'b0;
    #1;
    checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL areset_pre got %b exp 1", valid_o); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
      errors++; $display("FAIL areset_ctrl got v=%b r=%b exp v=0 r=1", valid_o, ready_o);
    end
    checks++; if (obs !== 75'd0) begin errors++; $display("FAIL areset_payload got %h exp 0", obs); end
    @(negedge clk);
    rst_n = 1'b1;
    ready_i = 1'b1;
    @(negedge clk); #1;
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL areset_after got %b exp 0", valid_o); end
  endtask

  initial begin
    test_reset();
    test_decode_directed();
    test_back_to_back();
    test_flush();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_alu_issue.md
Name: id_alu_issue

Overview:
- Decode-to-execute issue stage. Accepts a fetched instruction plus register-file read data over a valid/ready handshake, and decodes RV32I ALU-class instructions into the 4-bit ALU op code and the two ALU operands.
- Presents the decoded result to the execute stage through a 2-entry skid buffer, so ready_o is registered and throughput is one instruction per clock.
- Sits between the register-file read and the ALU. It is the producer end of the ALU op/operand interface.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- valid_i  in  1  upstream instruction valid.
- ready_o  out  1  upstream ready; registered.
- instr_i  in  32  instruction word.
- pc_i  in  32  instruction address.
- rs1_data_i  in  32  rs1 register value.
- rs2_data_i  in  32  rs2 register value.
- flush_i  in  1  synchronous kill of all buffered and incoming instructions.
- valid_o  out  1  decoded entry valid.
- ready_i  in  1  execute-stage ready.
- alu_op_o  out  4  ALU op: 0000 ADD, 0001 SUB, 0010 SLL, 0011 SLT, 0100 SLTU, 0101 XOR, 0110 SRL, 0111 SRA, 1000 OR, 1001 AND, 1010 LUI.
- alu1_o  out  32  ALU operand 1.
- alu2_o  out  32  ALU operand 2.
- rd_o  out  5  destination register.
- rd_we_o  out  1  writeback enable.
- illegal_o  out  1  instruction is not a legal ALU-class instruction.

Behaviour:
- Transfers:
  - Upstream transfer occurs when valid_i && ready_o.
  - Downstream transfer occurs when valid_o && ready_i.
  - Once asserted, valid_o and all payload outputs stay stable until the downstream transfer.
- Reset:
  - valid_o=0, ready_o=1, state EMPTY.
  - alu_op_o, alu1_o, alu2_o, rd_o, rd_we_o, illegal_o all 0.
  - Reset asserted mid-operation discards every buffered entry immediately.
- Decode is combinational on the input side; the result is registered into the buffer.
  - Latency: an instruction accepted at edge N is visible on valid_o after edge N.
- Decode rules (opcode = instr[6:0], funct3 = [14:12], funct7 = [31:25]):
  - OP 0110011: alu1=rs1_data, alu2=rs2_data.
    - funct3 000/101 use funct7 0000000 for ADD/SRL and 0100000 for SUB/SRA.
    - funct3 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 110 OR, 111 AND require funct7=0000000.
    - Any other funct7 is illegal.
  - OP-IMM 0010011: alu1=rs1_data, alu2=sign-extended instr[31:20].
    - SLLI requires funct7=0000000; alu2={27'b0, instr[24:20]}.
    - funct3 101 with funct7 0000000 gives SRL; funct7 0100000 gives SRA; any other funct7 is illegal.
    - funct3 000 is always ADD; there is no SUBI.
  - LUI 0110111: op LUI, alu1=0, alu2={instr[31:12],12'b0}.
  - AUIPC 0010111: op ADD, alu1=pc_i, alu2={instr[31:12],12'b0}.
  - Any other opcode, or an illegal funct field:
    - illegal_o=1, alu_op=ADD, alu1=alu2=0, rd_we_o=0.
    - The entry still flows through in order.
  - rd_o=instr[11:7]; rd_we_o = !illegal && rd != 0.
- Skid-buffer FSM:
  - States: EMPTY (0 entries), ONE (main register holds 1), TWO (main + skid).
  - Transitions:
    - EMPTY: accept -> ONE.
    - ONE: accept and drain -> ONE; accept only -> TWO; drain only -> EMPTY.
    - TWO: drain -> ONE, with the skid entry moving to main; no accept is possible.
  - ready_o is registered and equals (next_state != TWO).
  - Ordering is strict FIFO; no entry is lost or duplicated under any pattern of ready_i.
- flush_i:
  - At the next edge the state becomes EMPTY, valid_o=0, ready_o=1.
  - An input offered in the flush cycle is dropped.
  - A downstream transfer in the flush cycle still counts as completed.
  - Flush has priority over accept.

Decomposition:
- Shared package: opcode constants; funct7 constants; the 4-bit ALU op encodings above, shared with the ALU; the FSM state encoding.
- One sub-module, alu_decode: purely combinational instr/pc/rs data -> {alu_op, alu1, alu2, rd, rd_we, illegal}.
- id_alu_issue holds only the FSM and the two payload registers.

Test Plan:
- ADD x3,x1,x2 (0x002081B3), rs1=5, rs2=7, ready_i=1 -> next cycle valid_o=1, alu_op 0000, alu1=5, alu2=7, rd=3, rd_we=1.
- SUB 0x402081B3 -> alu_op 0001. SRAI x5,x6,3 (0x40335293), rs1=0x80000000 -> alu_op 0111, alu2=3, rd=5.
- LUI x1,0x12345 (0x123450B7) -> alu_op 1010, alu1=0, alu2=0x12345000. AUIPC x1,1 (0x00001097), pc=0x100 -> alu_op 0000, alu1=0x100, alu2=0x1000.
- ADDI x1,x0,-1 (0xFFF00093) -> alu2=0xFFFFFFFF. Opcode 0x03 or OP with funct7=0000001 -> illegal_o=1, rd_we_o=0.
- Back-to-back valid_i with ready_i held low 3 cycles -> two instructions accepted, then ready_o=0. After ready_i rises, all instructions emerge in order with no gaps or loss.
- State TWO, flush_i pulsed with valid_i high -> next cycle valid_o=0, ready_o=1, flushed instruction never appears. Reset pulse mid-stream -> outputs 0 asynchronously.
